// File: rtl/ex_divider_if.sv
// EX-stage divider bus: request/operands from the pipeline, stall/done/results back.
interface ex_divider_if;
    logic        ex_div;
    logic        ex_sign;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic        flush;
    logic        div_stall;
    logic        div_done;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    // Pipeline side: issues requests and consumes results.
    modport master (
        output ex_div,
        output ex_sign,
        output ex_rs_data,
        output ex_rt_data,
        output flush,
        input  div_stall,
        input  div_done,
        input  div_hi,
        input  div_lo
    );

    // Divider side.
    modport slave (
        input  ex_div,
        input  ex_sign,
        input  ex_rs_data,
        input  ex_rt_data,
        input  flush,
        output div_stall,
        output div_done,
        output div_hi,
        output div_lo
    );
endinterface

// File: rtl/ex_divider.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
// Operates on magnitudes and applies sign correction when results are registered;
// 32 iterations, so a request seen in IDLE at cycle T yields div_done at T+33.
module ex_divider (
    input  logic        clk,
    input  logic        rst,
    ex_divider_if.slave div_io
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        qsign_q;
    logic        rsign_q;
    logic        dbz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Operand magnitudes; raw values for unsigned requests.
    always_comb begin
        rs_abs = div_io.ex_rs_data;
        rt_abs = div_io.ex_rt_data;
        if (div_io.ex_sign && div_io.ex_rs_data[31]) begin
            rs_abs = ~div_io.ex_rs_data + 32'd1;
        end
        if (div_io.ex_sign && div_io.ex_rt_data[31]) begin
            rt_abs = ~div_io.ex_rt_data + 32'd1;
        end
    end

    // One restoring step: shift {rem, quo} left, trial-subtract, keep if non-negative.
    // shifted < 2*divisor, so bit 32 of the 33-bit difference is the borrow.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[32]) begin
            rem_nx = trial[31:0];
            quo_nx = {quo_q[30:0], 1'b1};
        end else begin
            rem_nx = shifted[31:0];
            quo_nx = {quo_q[30:0], 1'b0};
        end
    end

    // Sign correction of the final step. With a zero divisor the loop leaves
    // rem = |rs|, so re-applying the dividend sign restores the raw dividend.
    always_comb begin
        res_hi = rsign_q ? (~rem_nx + 32'd1) : rem_nx;
        if (dbz_q) begin
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_lo = qsign_q ? (~quo_nx + 32'd1) : quo_nx;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (div_io.ex_div && !div_io.flush) begin
                        state_q <= StCalc;
                        cnt_q   <= 6'd0;
                        rem_q   <= 32'd0;
                        quo_q   <= rs_abs;
                        dvs_q   <= rt_abs;
                        qsign_q <= div_io.ex_sign
                                   & (div_io.ex_rs_data[31] ^ div_io.ex_rt_data[31]);
                        rsign_q <= div_io.ex_sign & div_io.ex_rs_data[31];
                        dbz_q   <= (div_io.ex_rt_data == 32'd0);
                    end
                end
                StCalc: begin
                    if (div_io.flush) begin
                        // Abandon silently; results keep their previous values.
                        state_q <= StIdle;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        if (cnt_q == 6'd31) begin
                            state_q <= StDone;
                            hi_q    <= res_hi;
                            lo_q    <= res_lo;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                // Same instruction is still in EX here, so never restart from DONE.
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stall freezes the front end while a division is pending; dropped by flush and reset.
    assign div_io.div_stall = ~rst & ~div_io.flush
                              & (((state_q == StIdle) & div_io.ex_div) | (state_q == StCalc));
    assign div_io.div_done  = ~rst & (state_q == StDone);
    assign div_io.div_hi    = hi_q;
    assign div_io.div_lo    = lo_q;

endmodule

// File: doc/ex_divider.md
EX_DIVIDER -- requirements
Module: ex_divider

Interface
REQ-001 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 ex_div  input  1  EX-stage divide request; from the ID/EX register, held stable while stall is high.
REQ-004 ex_sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-005 ex_rs_data  input  32  dividend.
REQ-006 ex_rt_data  input  32  divisor.
REQ-007 flush  input  1  pipeline cancel from a branch or exception; aborts any division in progress.
REQ-008 div_stall  output  1  freeze request to PC, IF/ID and ID/EX; combinational.
REQ-009 div_done  output  1  one-cycle pulse; div_hi and div_lo are valid.
REQ-010 div_hi  output  32  remainder, registered.
REQ-011 div_lo  output  32  quotient, registered.

Function
REQ-012 States SHALL be exactly IDLE, CALC and DONE.
REQ-013 IDLE -> CALC when ex_div=1 and flush=0.
- Latch |rs| and |rt| (absolute values when ex_sign=1, raw values otherwise).
- Latch quotient sign = rs[31]^rt[31] and remainder sign = rs[31], both gated by ex_sign.
- Latch a divide-by-zero flag (rt==0).
- Clear the 6-bit iteration counter.
REQ-014 CALC SHALL perform one radix-2 restoring iteration per cycle, giving 32 iterations.
- Shift {rem, quo} left by 1.
- Trial-subtract the divisor from rem using a 33-bit subtract.
- If the result is non-negative, update rem and set quo[0]=1.
REQ-015 CALC -> DONE on the cycle in which the counter reaches 31.
- div_lo and div_hi SHALL be registered on that same edge.
REQ-016 DONE -> IDLE unconditionally after one cycle.
- DONE SHALL NOT start a new division, even if ex_div=1, because the same instruction is still in EX.
REQ-017 Result sign correction SHALL be applied when the results are registered (on the CALC -> DONE edge).
- Negate the quotient if the quotient sign is 1.
- Negate the remainder if the remainder sign is 1.
- All arithmetic wraps modulo 2^32.
REQ-018 div_stall SHALL equal (state==IDLE & ex_div & ~flush) | (state==CALC & ~flush).
- div_stall SHALL be 0 in DONE.
REQ-019 Latency: if the request is seen in IDLE in cycle T:
- div_stall is high in cycles T..T+32 (33 cycles);
- div_done is high in cycle T+33 only.
REQ-020 div_done SHALL equal (state==DONE); it is never high for two consecutive cycles.
REQ-021 Divide by zero: latency unchanged; div_lo=32'hFFFFFFFF and div_hi=ex_rs_data (unmodified dividend), whether signed or unsigned.
REQ-022 Signed overflow, 0x80000000 / 0xFFFFFFFF: div_lo=32'h80000000, div_hi=0; this is the natural wrap result and needs no special case.
REQ-023 flush in IDLE or CALC: next state is IDLE, no div_done is produced, and div_hi/div_lo are not modified.
REQ-024 flush in DONE: div_done is still asserted that cycle, and the state returns to IDLE.
REQ-025 Back-to-back: if ex_div=1 in the IDLE cycle immediately after DONE, a new division starts (this is a new instruction).
REQ-026 Operand changes on ex_rs_data and ex_rt_data during CALC SHALL have no effect; only the latched copies are used.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, counter=0, all internal registers cleared, div_hi=0, div_lo=0.
REQ-028 rst SHALL take priority over flush and ex_div.
REQ-029 During the reset cycle, div_stall=0 and div_done=0.
REQ-030 Reset mid-CALC SHALL abandon the operation silently, with no div_done.

Verification
REQ-031 Unsigned: rs=100, rt=7, sign=0 -> stall for 33 cycles, then div_done with div_lo=14, div_hi=2.
REQ-032 Signed: rs=0xFFFFFFF9 (-7), rt=2, sign=1 -> div_lo=0xFFFFFFFD (-3), div_hi=0xFFFFFFFF (-1); and rs=0x80000000, rt=0xFFFFFFFF -> div_lo=0x80000000, div_hi=0.
REQ-033 Divide by zero: rs=0x12345678, rt=0, sign=1 -> after 33 stall cycles, div_lo=0xFFFFFFFF, div_hi=0x12345678.
REQ-034 flush asserted in the 10th CALC cycle -> div_stall=0 the following cycle, state IDLE, no div_done, div_hi/div_lo keep their prior values.
REQ-035 Back-to-back: 100/7 then 0xFFFFFFFF/0x10 unsigned -> two div_done pulses exactly 34 cycles apart; second result div_lo=0x0FFFFFFF, div_hi=0xF.
REQ-036 Reset mid-CALC at cycle 5 -> all outputs 0, state IDLE; a subsequent 100/7 completes normally.
